// File: rtl/manchester_pkg.sv
// Shared types and helpers for the Manchester transmit sequencer.
package manchester_pkg;

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, GAP} tx_state_t;

    localparam logic [7:0] SFD_DEFAULT = 8'hD5;

    // Bit counter must index the longest per-state run: preamble, a byte, or the gap.
    function automatic int cnt_width(input int preamble_bits, input int gap_bits);
        int widest;
        widest = 8;
        if (preamble_bits > widest) widest = preamble_bits;
        if (gap_bits > widest) widest = gap_bits;
        return $clog2(widest);
    endfunction

endpackage

// File: rtl/manchester_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled, flags the terminal count.
module manchester_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic boundary
);
    localparam int            TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TC = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q;

    assign boundary = en && (cnt_q == TC);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= boundary ? '0 : cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/manchester_tx_ctrl.sv
// Frame sequencer feeding the Manchester encoder: preamble, SFD, MSB-first payload, idle gap.
//  state    | meaning
//  IDLE     | waiting for s_valid, line quiet
//  PREAMBLE | alternating 1,0 training bits
//  SFD      | delimiter byte, MSB first
//  DATA     | payload byte from the shift register
//  GAP      | inter-frame idle, tx_en low
module manchester_tx_ctrl #(
    parameter int         CLKS_PER_BIT  = 4,
    parameter int         PREAMBLE_BITS = 8,
    parameter logic [7:0] SFD           = manchester_pkg::SFD_DEFAULT,
    parameter int         GAP_BITS      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       tx_bit,
    output logic       tx_en,
    output logic       bit_strobe,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);
    import manchester_pkg::*;

    localparam int            CW        = cnt_width(PREAMBLE_BITS, GAP_BITS);
    localparam logic [CW-1:0] PRE_LAST  = CW'(PREAMBLE_BITS - 1);
    localparam logic [CW-1:0] BYTE_LAST = CW'(7);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_BITS - 1);

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          last_q, last_d;
    logic          tx_bit_d, tx_en_d, strobe_d, done_d, underrun_d;
    logic          boundary, fetch_point, go_fetch, go_gap;

    manchester_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q != IDLE),
        .clr      (state_q == IDLE),
        .boundary (boundary)
    );

    assign fetch_point = boundary && (cnt_q == BYTE_LAST) &&
                         ((state_q == manchester_pkg::SFD) || (state_q == DATA && !last_q));
    assign s_ready     = fetch_point && !rst;
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        last_d     = last_q;
        tx_bit_d   = tx_bit;
        tx_en_d    = tx_en;
        strobe_d   = 1'b0;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        go_fetch   = 1'b0;
        go_gap     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_bit_d = 1'b0;
                tx_en_d  = 1'b0;
                if (s_valid) begin
                    state_d  = PREAMBLE;
                    cnt_d    = '0;
                    tx_bit_d = 1'b1;
                    tx_en_d  = 1'b1;
                    strobe_d = 1'b1;
                end
            end
            PREAMBLE: if (boundary) begin
                strobe_d = 1'b1;
                if (cnt_q == PRE_LAST) begin
                    state_d  = manchester_pkg::SFD;
                    cnt_d    = '0;
                    tx_bit_d = SFD[7];
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    tx_bit_d = cnt_q[0];   // next preamble bit is the inverse of bit (cnt+1)[0]
                end
            end
            manchester_pkg::SFD: if (boundary) begin
                strobe_d = 1'b1;
                if (cnt_q == BYTE_LAST) begin
                    go_fetch = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    tx_bit_d = SFD[3'd6 - cnt_q[2:0]];
                end
            end
            DATA: if (boundary) begin
                strobe_d = 1'b1;
                if (cnt_q == BYTE_LAST) begin
                    if (last_q) go_gap = 1'b1;
                    else        go_fetch = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    shift_d  = {shift_q[6:0], 1'b0};
                    tx_bit_d = shift_q[6];
                end
            end
            GAP: if (boundary) begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    strobe_d = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (go_fetch) begin
            if (s_valid) begin
                state_d  = DATA;
                cnt_d    = '0;
                shift_d  = s_data;
                last_d   = s_last;
                tx_bit_d = s_data[7];
                tx_en_d  = 1'b1;
            end else begin
                underrun_d = 1'b1;
                go_gap     = 1'b1;
            end
        end
        if (go_gap) begin
            state_d  = GAP;
            cnt_d    = '0;
            tx_bit_d = 1'b0;
            tx_en_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            last_q     <= 1'b0;
            tx_bit     <= 1'b0;
            tx_en      <= 1'b0;
            bit_strobe <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            tx_bit     <= tx_bit_d;
            tx_en      <= tx_en_d;
            bit_strobe <= strobe_d;
            frame_done <= done_d;
            underrun   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_manchester_tx_ctrl.sv
// Scoreboard bench: frame model pushes expected bits/fetches/frame ends; a monitor checks them.
module tb_manchester_tx_ctrl;
    localparam int         CPB = 4;
    localparam int         PRE = 8;
    localparam int         GAPB = 4;
    localparam logic [7:0] SFD_V = 8'hD5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready, tx_bit, tx_en, bit_strobe, busy, frame_done, underrun;

    manchester_tx_ctrl #(
        .CLKS_PER_BIT(CPB), .PREAMBLE_BITS(PRE), .SFD(SFD_V), .GAP_BITS(GAPB)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .tx_bit(tx_bit), .tx_en(tx_en), .bit_strobe(bit_strobe),
        .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int total;
        bit ur;
        int ur_idx;
    } frame_exp_t;

    logic [1:0] exp_bits[$];   // {tx_en, tx_bit} per bit period
    int         exp_fetch[$];  // bit index whose last cycle carries s_ready
    frame_exp_t exp_end[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the frame as a list of bit periods built from the framing rules.
    task automatic push_frame(input logic [7:0] bytes[$], input int ur_at);
        logic [7:0] sfd;
        logic [7:0] b;
        frame_exp_t f;
        int nacc;
        sfd = SFD_V;
        nacc = (ur_at < 0) ? bytes.size() : ur_at;
        for (int i = 0; i < PRE; i++) exp_bits.push_back({1'b1, (i % 2 == 0) ? 1'b1 : 1'b0});
        for (int i = 0; i < 8; i++) exp_bits.push_back({1'b1, sfd[7-i]});
        for (int j = 0; j < nacc; j++) begin
            b = bytes[j];
            for (int i = 0; i < 8; i++) exp_bits.push_back({1'b1, b[7-i]});
        end
        for (int i = 0; i < GAPB; i++) exp_bits.push_back(2'b00);
        for (int j = 0; j < ((ur_at < 0) ? bytes.size() : ur_at + 1); j++)
            exp_fetch.push_back(PRE + 7 + 8 * j);
        f.total  = PRE + 8 + 8 * nacc + GAPB;
        f.ur     = (ur_at >= 0);
        f.ur_idx = (ur_at >= 0) ? PRE + 8 + 8 * nacc : -1;
        exp_end.push_back(f);
    endtask

    // Monitor
    int  nbits = 0;
    int  since = 0;
    bit  ur_seen = 1'b0;
    always @(negedge clk) begin
        logic [1:0] e;
        frame_exp_t f;
        if (!mon_en) begin
            nbits = 0; since = 0; ur_seen = 1'b0;
        end else begin
            if (bit_strobe) begin
                if (nbits > 0) chk("bit_period", since + 1, CPB);
                since = 0;
                if (exp_bits.size() == 0) chk("unexpected_bit", 1, 0);
                else begin
                    e = exp_bits.pop_front();
                    chk("tx_en", tx_en, e[1]);
                    chk("tx_bit", tx_bit, e[0]);
                end
                nbits++;
            end else begin
                since++;
            end
            if (s_ready) begin
                chk("ready_phase", since, CPB - 1);
                if (exp_fetch.size() == 0) chk("unexpected_ready", 1, 0);
                else chk("ready_bit", nbits - 1, exp_fetch.pop_front());
            end
            if (underrun) begin
                chk("underrun_strobe", bit_strobe, 1);
                chk("underrun_tx_en", tx_en, 0);
                ur_seen = 1'b1;
                if (exp_end.size() == 0) chk("unexpected_underrun", 1, 0);
                else chk("underrun_bit", nbits - 1, exp_end[0].ur_idx);
            end
            if (frame_done) begin
                if (exp_end.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    f = exp_end.pop_front();
                    chk("frame_bits", nbits, f.total);
                    chk("done_phase", since, CPB);
                    chk("underrun_seen", ur_seen, f.ur);
                end
                nbits = 0;
                ur_seen = 1'b0;
            end
            chk("busy", busy, (nbits > 0) ? 1 : 0);
        end
    end

    // Drives one frame starting at the current negedge; returns at the frame_done negedge.
    task automatic run_frame(input logic [7:0] bytes[$], input int ur_at);
        int j;
        bit done;
        j = 0;
        done = 1'b0;
        push_frame(bytes, ur_at);
        s_valid = 1'b1;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            if (frame_done) begin
                done = 1'b1;
            end else if (s_ready) begin
                s_valid = (j != ur_at);
                s_data  = (j < bytes.size()) ? bytes[j] : 8'($urandom);
                s_last  = (j == bytes.size() - 1);
                j++;
            end else begin
                s_valid = 1'($urandom);
                s_data  = 8'($urandom);
                s_last  = 1'($urandom);
            end
        end
        if (!done) chk("frame_timeout", 0, 1);
    endtask

    task automatic idle_cycles(input int n);
        s_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] b0;
        int n, ur;

        repeat (3) @(negedge clk);
        chk("rst_tx_bit", tx_bit, 0);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_strobe", bit_strobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ready", s_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);

        q = '{8'hA5};                 run_frame(q, -1); idle_cycles(3);
        q = '{8'h00, 8'hFF, 8'h3C};   run_frame(q, -1); idle_cycles(2);
        q = '{8'h5A, 8'h77};          run_frame(q, 1);  idle_cycles(2);
        q = '{8'h12};                 run_frame(q, 0);  idle_cycles(1);
        q = '{8'hC3};                 run_frame(q, -1);

        // Random frames, mostly back-to-back straight after frame_done
        for (int k = 0; k < 8; k++) begin
            q.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            ur = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            run_frame(q, ur);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 5));
        end
        idle_cycles(4);
        chk("bits_left", exp_bits.size(), 0);
        chk("fetch_left", exp_fetch.size(), 0);
        chk("ends_left", exp_end.size(), 0);

        // Reset in the middle of payload bit 3 of byte 0
        mon_en = 1'b0;
        @(negedge clk);
        b0 = 8'($urandom);
        s_valid = 1'b1;
        for (int k = 1; k <= 78; k++) begin
            @(negedge clk);
            if (s_ready) begin
                s_valid = 1'b1; s_data = b0; s_last = 1'b1;
            end else begin
                s_valid = 1'($urandom); s_data = 8'($urandom); s_last = 1'($urandom);
            end
        end
        chk("pre_rst_tx_en", tx_en, 1);
        chk("pre_rst_tx_bit", tx_bit, b0[4]);
        rst = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_tx_bit", tx_bit, 0);
        chk("mid_rst_tx_en", tx_en, 0);
        chk("mid_rst_strobe", bit_strobe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", frame_done, 0);
        chk("mid_rst_underrun", underrun, 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("post_rst_idle", {busy, frame_done, tx_en, bit_strobe, s_ready}, 0);
        end
        mon_en = 1'b1;
        @(negedge clk);

        q = '{8'h96, 8'h01};
        run_frame(q, -1);
        idle_cycles(4);
        chk("bits_left_end", exp_bits.size(), 0);
        chk("fetch_left_end", exp_fetch.size(), 0);
        chk("ends_left_end", exp_end.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/manchester_tx_ctrl.md
Name: manchester_tx_ctrl

Overview:
- Frame-level transmit sequencer that drives the data_in bit stream of the Manchester encoder.
- Accepts payload bytes on a valid/ready stream and emits a framed serial bitstream: alternating preamble, start-of-frame delimiter (SFD), payload MSB-first, then an idle inter-frame gap.
- Paces each bit for a fixed number of clocks, so the encoder and decoder see a steady bit rate.

Parameters:
- CLKS_PER_BIT, 4: clocks each serial bit is held; minimum 2.
- PREAMBLE_BITS, 8: preamble length in bits; pattern 1,0,1,0,...; minimum 2.
- SFD, 8'hD5: delimiter byte, sent MSB-first.
- GAP_BITS, 4: idle bit periods after each frame; minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- s_data  input  8  payload byte
- s_valid  input  1  s_data/s_last valid
- s_last  input  1  current byte is the last of the frame
- s_ready  output  1  byte accepted this cycle when s_valid=1
- tx_bit  output  1  serial bit to the encoder's data_in
- tx_en  output  1  1 while a frame bit is on tx_bit
- bit_strobe  output  1  one-cycle pulse on the first clock of each new bit
- busy  output  1  1 in any state other than IDLE
- frame_done  output  1  one-cycle pulse when a frame's gap completes
- underrun  output  1  one-cycle pulse when a frame is aborted for missing data

Behaviour:
- Reset, one clock, synchronous, active-high:
  - state=IDLE; bit timer, bit counter and shift register cleared.
  - All outputs 0.
  - rst in any state aborts immediately; no frame_done or underrun pulse.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 while busy; the terminal count is the bit boundary.
  - tx_bit, tx_en and bit_strobe are registered and update on the clock after the boundary.
- FSM states: IDLE, PREAMBLE, SFD, DATA, GAP.
- IDLE:
  - s_ready=0, tx_en=0, tx_bit=0.
  - s_valid=1 at cycle N -> PREAMBLE. At N+1: tx_en=1, tx_bit=1, bit_strobe=1, busy=1.
  - The pending byte is not consumed in IDLE.
- PREAMBLE: PREAMBLE_BITS bits, alternating, starting with 1. Then SFD.
- SFD: 8 bits of SFD, MSB-first.
- Byte fetch, at the boundary ending the last SFD bit or the last bit of a non-last payload byte:
  - s_ready=1 for exactly that one cycle (combinational s_ready = boundary AND fetch point).
  - If s_valid=1: load s_data into the shift register, latch s_last, go to or stay in DATA.
  - If s_valid=0: underrun pulse, go to GAP with tx_en=0.
- DATA:
  - 8 bits per byte, MSB-first.
  - After bit 0 of a byte whose latched s_last=1 -> GAP, with no fetch.
- GAP:
  - tx_en=0, tx_bit=0 for GAP_BITS bit periods.
  - bit_strobe continues to pulse, busy=1.
  - At the end of the gap: frame_done pulse, then IDLE.
  - An underrun-aborted frame also pulses frame_done after its gap.
- Frame length:
  - Total bit periods per frame = PREAMBLE_BITS + 8 + 8*nbytes + GAP_BITS.
  - Back-to-back frames: earliest restart is the cycle after frame_done.
- Payload stability:
  - s_data, s_last and s_valid changes outside an s_ready cycle are ignored.
  - No byte is ever accepted outside an s_ready cycle.
- Counter widths:
  - Bit timer: $clog2(CLKS_PER_BIT).
  - Bit counter: wide enough for max(PREAMBLE_BITS, 8, GAP_BITS); it wraps only by explicit reload per state.

Decomposition:
- Shared package manchester_pkg:
  - State enum tx_state_t {IDLE, PREAMBLE, SFD, DATA, GAP}.
  - SFD default constant, 8'hD5.
  - Width helper for the bit counter.
- One natural sub-module, manchester_bit_timer: a CLKS_PER_BIT divider with enable, clear and boundary output.
- FSM and shifter stay in the top.

Test Plan:
- Reset then a 1-byte frame 8'hA5 with s_last=1, CLKS_PER_BIT=4 -> tx_bit sequence:
  - 10101010, then 11010101, then 10100101, while tx_en=1.
  - Then 4 gap bits with tx_en=0.
  - frame_done at cycle 4*(8+8+8+4)=112 after the start; s_ready high exactly once.
- 3-byte frame 8'h00, 8'hFF, 8'h3C with s_valid held high -> s_ready pulses at bit periods 16, 24 and 32. Payload bits match MSB-first. One frame_done.
- Underrun: 2-byte frame, s_valid dropped at the second fetch -> underrun pulse at that boundary. tx_en=0 from the next bit, gap follows, frame_done fires, no second byte consumed.
- Reset asserted mid-DATA (bit 3 of byte 0) -> next cycle all outputs 0, state IDLE, no frame_done.
- Back-to-back frames, s_valid high at frame_done -> the next preamble starts the cycle after frame_done; no bit lost or duplicated.
- Loopback through the encoder and decoder with 8'hC3 -> decoded output reproduces preamble, SFD and 8'hC3 bits in order, at the decoder's fixed latency.
